// File: rtl/jtag_l2_pkg.sv
// Shared types for the JTAG-to-L2 burst engine: FSM states, the latched command record
// and the all-ones byte-enable source.
package jtag_l2_pkg;

  // Field widths of the latched command record
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_LEN_W  = 8;

  localparam int BE_MAX_W = 64;
  localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/jtag_l2_rdata_fifo.sv
// Synchronous read-data FIFO; rst_i clears all entries, and a push with a pop is legal when full.
module jtag_l2_rdata_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/jtag_l2_burst_engine.sv
// Command-driven burst read/write engine from the JTAG debug path into an L2 req/gnt/rvalid port.
// Optional grant timeout is compiled in with `define JTAG_L2_TIMEOUT_EN.
module jtag_l2_burst_engine
  import jtag_l2_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST     = 256,
  parameter int RD_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_we_i,
  input  logic [ADDR_W-1:0]            cmd_addr_i,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len_i,
  input  logic                         wdata_valid_i,
  output logic                         wdata_ready_o,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic                         rdata_valid_o,
  input  logic                         rdata_ready_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [DATA_W/8-1:0]          mem_be_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i
);

  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  if (ADDR_W != CMD_ADDR_W || LEN_W != CMD_LEN_W) begin : g_bad_cmd_width
    $error("jtag_l2_burst_engine: ADDR_W/MAX_BURST do not match the cmd_t field widths");
  end
  if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0 || BE_W > BE_MAX_W) begin : g_bad_data_w
    $error("jtag_l2_burst_engine: DATA_W must be a power of 2 between 8 and 512");
  end
  if (RD_FIFO_DEPTH < 2 || TIMEOUT_CYC < 1) begin : g_bad_depth
    $error("jtag_l2_burst_engine: RD_FIFO_DEPTH must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;

  logic             gnt, rd_gnt, push, pop, flush, misaligned;
  logic             rd_room, fifo_drained, drain_exit;
  logic [CNT_W:0]   credit_used;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;

`ifdef JTAG_L2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            abort_q, abort_d;
`endif

  assign misaligned = (cmd_addr_i & ADDR_W'(BE_W - 1)) != '0;
  // Reads in flight plus words already queued may never exceed the FIFO, so every rvalid has a slot
  assign credit_used  = {1'b0, outst_q} + {1'b0, fifo_count};
  assign rd_room      = !fifo_full && (credit_used < (CNT_W + 1)'(RD_FIFO_DEPTH));
  assign push         = mem_rvalid_i && (outst_q != '0);
  assign pop          = rdata_valid_o && rdata_ready_i;
  assign fifo_drained = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    beat_d        = beat_q;
    outst_d       = outst_q;
    err_d         = err_q;
    cmd_ready_o   = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    flush         = 1'b0;
    drain_exit    = fifo_drained;
`ifdef JTAG_L2_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    abort_d       = abort_q;
    flush         = abort_q && (state_q == RD_DRAIN);
    drain_exit    = fifo_drained || abort_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cmd_d.we   = cmd_we_i;
          cmd_d.addr = cmd_addr_i;
          cmd_d.len  = cmd_len_i;
          beat_d     = '0;
          err_d      = misaligned;
`ifdef JTAG_L2_TIMEOUT_EN
          to_cnt_d   = '0;
          abort_d    = 1'b0;
`endif
          if (misaligned) state_d = DONE;
          else            state_d = cmd_we_i ? WR : RD;
        end
      end
      WR: begin
        mem_req_o = wdata_valid_i;
        mem_we_o  = 1'b1;
      end
      RD: begin
        mem_req_o = rd_room;
      end
      RD_DRAIN: begin
        if ((outst_q == '0) && drain_exit) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gnt    = mem_req_o && mem_gnt_i;
    rd_gnt = gnt && !cmd_q.we;

    if (gnt) begin
      cmd_d.addr = cmd_q.addr + ADDR_W'(BE_W);
      beat_d     = beat_q + LEN_W'(1);
      if (beat_q == cmd_q.len) state_d = cmd_q.we ? DONE : RD_DRAIN;
    end

    if (rd_gnt && !push)      outst_d = outst_q + CNT_W'(1);
    else if (!rd_gnt && push) outst_d = outst_q - CNT_W'(1);

`ifdef JTAG_L2_TIMEOUT_EN
    // Stalled requests are abandoned after TIMEOUT_CYC ungranted cycles
    if (gnt) begin
      to_cnt_d = '0;
    end else if (mem_req_o) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        to_cnt_d = '0;
        err_d    = 1'b1;
        if (cmd_q.we) begin
          state_d = DONE;
        end else begin
          state_d = RD_DRAIN;
          abort_d = 1'b1;
        end
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      beat_q   <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
`ifdef JTAG_L2_TIMEOUT_EN
      to_cnt_q <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      beat_q   <= beat_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
`ifdef JTAG_L2_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      abort_q  <= abort_d;
`endif
    end
  end

  jtag_l2_rdata_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rdata_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i || flush),
    .push_i  (push),
    .data_i  (mem_rdata_i),
    .pop_i   (pop),
    .data_o  (rdata_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rdata_valid_o = !fifo_empty && !flush;
  assign wdata_ready_o = gnt && cmd_q.we;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign err_o         = done_o && err_q;
  assign mem_be_o      = mem_req_o ? BE_ALL_ONES[BE_W-1:0] : '0;
  assign mem_addr_o    = cmd_q.addr;
  assign mem_wdata_o   = (state_q == WR) ? wdata_i : '0;

endmodule

// File: tb/tb_jtag_l2_burst_engine.sv
// Directed bench for jtag_l2_burst_engine with a grant-on-demand L2 model (rvalid 1 cycle after grant).
// The grant-timeout case runs only when JTAG_L2_TIMEOUT_EN is defined.
module tb_jtag_l2_burst_engine;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MAX_BURST     = 256;
  localparam int RD_FIFO_DEPTH = 4;
  localparam int TIMEOUT_CYC   = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [31:0] wdata_i = '0;
  logic        rdata_valid_o;
  logic        rdata_ready_i = 1'b0;
  logic [31:0] rdata_o;
  logic        busy_o, done_o, err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int          checks = 0;
  int          errors = 0;
  int          doneCnt = 0;
  bit          gntEn = 1'b0;
  logic [31:0] reqAddr [$];
  logic [31:0] reqData [$];
  logic [31:0] expData [8];

  jtag_l2_burst_engine #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_BURST     (MAX_BURST),
    .RD_FIFO_DEPTH (RD_FIFO_DEPTH),
    .TIMEOUT_CYC   (TIMEOUT_CYC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready_i),
    .rdata_o       (rdata_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // L2 model: grant while enabled, read data is 0xDEAD in the top half and the low address half below
  assign mem_gnt_i = mem_req_o && gntEn;

  always @(posedge clk_i) begin
    mem_rvalid_i <= mem_req_o && mem_gnt_i && !mem_we_o;
    mem_rdata_i  <= {16'hDEAD, mem_addr_o[15:0]};
    if (mem_req_o && mem_gnt_i) begin
      reqAddr.push_back(mem_addr_o);
      reqData.push_back(mem_wdata_o);
    end
    if (done_o) doneCnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [7:0] len);
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic clearLog();
    reqAddr.delete();
    reqData.delete();
  endtask

  task automatic drainRead(input string tag, input int n);
    int idx = 0;
    rdata_ready_i = 1'b1;
    for (int i = 0; i < 64 && idx < n; i++) begin
      if (rdata_valid_o) begin
        checkOutput({tag, "_data"}, rdata_o, expData[idx]);
        idx++;
      end
      @(negedge clk_i);
    end
    checkOutput({tag, "_words"}, idx, n);
    checkOutput({tag, "_done"}, done_o, 1);
    checkOutput({tag, "_err"}, err_o, 0);
    checkOutput({tag, "_empty"}, rdata_valid_o, 0);
    rdata_ready_i = 1'b0;
  endtask

  initial begin
    int  d0;
    bit  sawDone;

    $display("[TB] start");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    checkOutput("rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_req", mem_req_o, 0);
    checkOutput("rst_be", mem_be_o, 0);
    checkOutput("rst_rvalid", rdata_valid_o, 0);
    checkOutput("rst_wready", wdata_ready_o, 0);

    // Single write, immediate grant
    clearLog();
    d0 = doneCnt;
    gntEn = 1'b1;
    wdata_valid_i = 1'b1;
    wdata_i = 32'hABBA_ABBA;
    applyStimulus(1'b1, 32'h0000_0000, 8'd0);
    checkOutput("wr1_req", mem_req_o, 1);
    checkOutput("wr1_we", mem_we_o, 1);
    checkOutput("wr1_be", mem_be_o, 4'hF);
    checkOutput("wr1_wdata", mem_wdata_o, 32'hABBA_ABBA);
    checkOutput("wr1_wready", wdata_ready_o, 1);
    checkOutput("wr1_busy", busy_o, 1);
    checkOutput("wr1_no_early_done", done_o, 0);
    @(negedge clk_i);
    wdata_valid_i = 1'b0;
    checkOutput("wr1_done", done_o, 1);
    checkOutput("wr1_err", err_o, 0);
    checkOutput("wr1_req_after", mem_req_o, 0);
    @(negedge clk_i);
    checkOutput("wr1_done_pulse", done_o, 0);
    checkOutput("wr1_cmd_ready", cmd_ready_o, 1);
    checkOutput("wr1_nreq", reqAddr.size(), 1);
    checkOutput("wr1_addr", reqAddr[0], 32'h0000_0000);
    checkOutput("wr1_data", reqData[0], 32'hABBA_ABBA);
    checkOutput("wr1_done_cnt", doneCnt - d0, 1);

    // Two-beat write with the grant held off: request must stay put
    clearLog();
    gntEn = 1'b0;
    wdata_valid_i = 1'b1;
    wdata_i = 32'h1111_2222;
    applyStimulus(1'b1, 32'h0000_0040, 8'd1);
    repeat (3) begin
      checkOutput("wrs_req_held", mem_req_o, 1);
      checkOutput("wrs_addr_held", mem_addr_o, 32'h0000_0040);
      @(negedge clk_i);
    end
    gntEn = 1'b1;
    @(negedge clk_i);
    checkOutput("wrs_addr_next", mem_addr_o, 32'h0000_0044);
    wdata_i = 32'h3333_4444;
    @(negedge clk_i);
    wdata_valid_i = 1'b0;
    checkOutput("wrs_done", done_o, 1);
    checkOutput("wrs_nreq", reqAddr.size(), 2);
    checkOutput("wrs_data0", reqData[0], 32'h1111_2222);
    checkOutput("wrs_data1", reqData[1], 32'h3333_4444);
    @(negedge clk_i);

    // Read of 4 words with consumer stalled, then drained in order
    clearLog();
    d0 = doneCnt;
    rdata_ready_i = 1'b0;
    applyStimulus(1'b0, 32'h0000_0100, 8'd3);
    repeat (8) @(negedge clk_i);
    checkOutput("rd4_nreq", reqAddr.size(), 4);
    checkOutput("rd4_addr0", reqAddr[0], 32'h0000_0100);
    checkOutput("rd4_addr1", reqAddr[1], 32'h0000_0104);
    checkOutput("rd4_addr2", reqAddr[2], 32'h0000_0108);
    checkOutput("rd4_addr3", reqAddr[3], 32'h0000_010C);
    checkOutput("rd4_req_stalled", mem_req_o, 0);
    checkOutput("rd4_busy", busy_o, 1);
    checkOutput("rd4_no_done", doneCnt - d0, 0);
    checkOutput("rd4_rvalid", rdata_valid_o, 1);
    checkOutput("rd4_head", rdata_o, 32'hDEAD_0100);
    expData[0] = 32'hDEAD_0100;
    expData[1] = 32'hDEAD_0104;
    expData[2] = 32'hDEAD_0108;
    expData[3] = 32'hDEAD_010C;
    drainRead("rd4", 4);
    @(negedge clk_i);
    checkOutput("rd4_done_cnt", doneCnt - d0, 1);

    // Read of 6 words: only 4 may be issued until the consumer pops
    clearLog();
    applyStimulus(1'b0, 32'h0000_0200, 8'd5);
    repeat (12) @(negedge clk_i);
    checkOutput("rd6_credit_nreq", reqAddr.size(), 4);
    checkOutput("rd6_credit_req", mem_req_o, 0);
    expData[0] = 32'hDEAD_0200;
    expData[1] = 32'hDEAD_0204;
    expData[2] = 32'hDEAD_0208;
    expData[3] = 32'hDEAD_020C;
    expData[4] = 32'hDEAD_0210;
    expData[5] = 32'hDEAD_0214;
    drainRead("rd6", 6);
    checkOutput("rd6_nreq", reqAddr.size(), 6);
    checkOutput("rd6_last_addr", reqAddr[5], 32'h0000_0214);
    @(negedge clk_i);

    // Maximum-length write running up to the top of the address space
    clearLog();
    d0 = doneCnt;
    sawDone = 1'b0;
    wdata_valid_i = 1'b1;
    wdata_i = 32'hC0DE_0000;
    applyStimulus(1'b1, 32'hFFFF_FC00, 8'hFF);
    for (int i = 0; i < 300 && !sawDone; i++) begin
      if (done_o) begin
        sawDone = 1'b1;
      end else begin
        wdata_i = 32'hC0DE_0000 + reqAddr.size();
        @(negedge clk_i);
      end
    end
    wdata_valid_i = 1'b0;
    checkOutput("wr256_done_seen", sawDone, 1);
    checkOutput("wr256_err", err_o, 0);
    checkOutput("wr256_nreq", reqAddr.size(), 256);
    checkOutput("wr256_first_addr", reqAddr[0], 32'hFFFF_FC00);
    checkOutput("wr256_last_addr", reqAddr[255], 32'hFFFF_FFFC);
    checkOutput("wr256_last_data", reqData[255], 32'hC0DE_00FF);
    @(negedge clk_i);
    checkOutput("wr256_done_once", doneCnt - d0, 1);

    // Misaligned command: error completion without memory traffic
    clearLog();
    d0 = doneCnt;
    applyStimulus(1'b0, 32'h0000_0002, 8'd0);
    checkOutput("mis_done", done_o, 1);
    checkOutput("mis_err", err_o, 1);
    checkOutput("mis_req", mem_req_o, 0);
    checkOutput("mis_cmd_ready_low", cmd_ready_o, 0);
    @(negedge clk_i);
    checkOutput("mis_done_pulse", done_o, 0);
    checkOutput("mis_cmd_ready", cmd_ready_o, 1);
    checkOutput("mis_nreq", reqAddr.size(), 0);
    checkOutput("mis_done_cnt", doneCnt - d0, 1);

    // Reset in the middle of a read with a grant in flight
    clearLog();
    d0 = doneCnt;
    rdata_ready_i = 1'b0;
    applyStimulus(1'b0, 32'h0000_0300, 8'd7);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rst_mid_busy", busy_o, 0);
    checkOutput("rst_mid_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_mid_fifo", rdata_valid_o, 0);
    checkOutput("rst_mid_late_rvalid", mem_rvalid_i, 1);
    @(negedge clk_i);
    checkOutput("rst_mid_ignore_rvalid", rdata_valid_o, 0);
    checkOutput("rst_mid_req", mem_req_o, 0);
    @(negedge clk_i);
    checkOutput("rst_mid_no_done", doneCnt - d0, 0);

    // Engine recovers after the mid-command reset
    clearLog();
    applyStimulus(1'b0, 32'h0000_0500, 8'd0);
    expData[0] = 32'hDEAD_0500;
    drainRead("rd1", 1);
    @(negedge clk_i);

`ifdef JTAG_L2_TIMEOUT_EN
    begin
      int reqCyc = 0;
      bit toDone = 1'b0;
      clearLog();
      gntEn = 1'b0;
      applyStimulus(1'b0, 32'h0000_0400, 8'd0);
      for (int i = 0; i < 64 && !toDone; i++) begin
        if (mem_req_o) reqCyc++;
        if (done_o) toDone = 1'b1;
        else @(negedge clk_i);
      end
      checkOutput("to_req_cycles", reqCyc, TIMEOUT_CYC);
      checkOutput("to_done", done_o, 1);
      checkOutput("to_err", err_o, 1);
      checkOutput("to_nreq", reqAddr.size(), 0);
      gntEn = 1'b1;
      @(negedge clk_i);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
